// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the RV32I pipeline control slice.
// No logic of its own: forwarding codes, result-select load code, wait-FSM states.
// The forwarding helper is pure combinational and has no backpressure.
package rv_pipe_pkg;

    localparam logic [1:0] FWD_RF       = 2'b00;
    localparam logic [1:0] FWD_WB       = 2'b01;
    localparam logic [1:0] FWD_MEM      = 2'b10;
    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } wait_state_t;

    // Forward select for one EX source register; the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic       regwrite_m,
        input logic [4:0] rd_m,
        input logic       regwrite_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks a MEM-stage slow-bus access: raises mem_wait until ack or timeout.
// mem_wait/mem_timeout are same-cycle combinational; error pulse is registered (+1 cycle).
// An ack arriving with the request costs no cycles; a timeout retires the access anyway.
module mem_wait_fsm
    import rv_pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ack,
    input  logic err_clr,
    output logic mem_wait,
    output logic mem_timeout,
    output logic bus_err_pulse,
    output logic bus_err_sticky
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    wait_state_t     state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    // Next-state, wait counter and same-cycle wait/timeout decode.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_wait    = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    mem_wait   = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < TO_LIM) begin
                    mem_wait   = 1'b1;
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end else begin
                    mem_timeout = 1'b1;
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // State, counter and error flags; a timeout in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            bus_err_pulse  <= 1'b0;
            bus_err_sticky <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_err_pulse <= mem_timeout;
            if (mem_timeout) begin
                bus_err_sticky <= 1'b1;
            end else if (err_clr) begin
                bus_err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage RV32I pipe, plus slow-bus freeze.
// Stall/flush/forward are same-cycle combinational; stall counter updates at the clock edge.
// A pending MEM bus access freezes every stage and bubbles WB until ack or timeout.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [1:0]       result_src_e,
    input  logic             pc_src_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             mem_req_m,
    input  logic             mem_ack,
    input  logic             err_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             bus_err_pulse,
    output logic             bus_err_sticky,
    output logic [CNT_W-1:0] stall_cycles
);

    logic mem_wait;
    logic mem_timeout;
    logic load_use;

    mem_wait_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_mem_wait_fsm (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req_m),
        .mem_ack        (mem_ack),
        .err_clr        (err_clr),
        .mem_wait       (mem_wait),
        .mem_timeout    (mem_timeout),
        .bus_err_pulse  (bus_err_pulse),
        .bus_err_sticky (bus_err_sticky)
    );

    assign load_use = (result_src_e == RES_SRC_LOAD) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Stage control: reset bubbles everything, bus wait freezes all, else load-use/branch.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            // A taken branch squashes the dependent instruction, so it overrides load-use.
            if (pc_src_e) begin
                stall_f = 1'b0;
                stall_d = 1'b0;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // EX operand forwarding, independent of the bus-wait state.
    always_comb begin
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        if (!rst) begin
            fwd_a_e = fwd_sel(regwrite_m, rd_m, regwrite_w, rd_w, rs1_e);
            fwd_b_e = fwd_sel(regwrite_m, rd_m, regwrite_w, rd_w, rs2_e);
        end
    end

    // Saturating count of cycles where fetch is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_f && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
